alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Hardware initiator for the 16-bit ALU. It accepts one command per transaction over a valid/ready handshake.
//  It reads the two operands from an internal 16x16 register file and drives the ALU ports (Opcode/Src/Dest).
//  It captures C and Flags, writes C back to the destination register and latches Flags into a status register.
//  It replaces the bench-driven stimulus with a synthesizable datapath front end.
// PARAMETERS
//  NREGS       16      register-file depth (address width = $clog2(NREGS))
//  CMP_OPCODE  8'h0B   opcode treated as compare (see CONFIGURATION)
// PORTS
//  clk          in   1   system clock, rising edge
//  reset_n      in   1   asynchronous, active-low reset
//  cmd_valid    in   1   command present
//  cmd_ready    out  1   sequencer can accept a command
//  cmd_opcode   in   8   ALU opcode
//  cmd_rsrc     in   4   source register index
//  cmd_rdest    in   4   destination register index (operand and writeback target)
//  wr_en        in   1   host register preload strobe
//  wr_addr      in   4   preload index
//  wr_data      in   16  preload data
//  rd_addr      in   4   debug read index
//  rd_data      out  16  combinational read of regfile[rd_addr]
//  alu_opcode   out  8   to ALU Opcode
//  alu_src      out  16  to ALU Src
//  alu_dest     out  16  to ALU Dest
//  alu_c        in   16  from ALU C (combinational ALU)
//  alu_flags    in   5   from ALU Flags
//  flags        out  5   last captured ALU flags
//  done         out  1   one-cycle pulse on writeback
// BEHAVIOUR
//  Reset (async, reset_n=0):
//   - state=IDLE; all regfile entries=0.
//   - alu_opcode/alu_src/alu_dest=0; flags=0; done=0.
//   - Takes effect mid-transaction; the in-flight command is discarded and no writeback occurs.
//  FSM states: IDLE -> ISSUE -> CAPTURE -> IDLE (fixed 3-cycle transaction).
//   - IDLE: cmd_ready = ~wr_en.
//     - If cmd_valid & cmd_ready: on the edge, register alu_opcode=cmd_opcode, alu_src=reg[rsrc] and alu_dest=reg[rdest].
//       Latch rdest; go to ISSUE.
//     - Else if wr_en: reg[wr_addr]=wr_data.
//     - wr_en has priority: a command is never accepted in a cycle with wr_en=1.
//   - ISSUE: cmd_ready=0; ALU inputs stable for one full cycle; go to CAPTURE.
//   - CAPTURE: cmd_ready=0.
//     - On the edge: reg[rdest]=alu_c; flags=alu_flags; done=1 for the following cycle; go to IDLE.
//  Latency: accept at edge N, ALU inputs valid from N, writeback at edge N+2, done high in cycle N+2..N+3.
//   - The next command can be accepted at edge N+3 (throughput 1 per 3 clk).
//  ALU outputs hold their last values in IDLE; they are not zeroed between commands.
//  Operands are sampled at accept; a later wr_en cannot alter an in-flight command (wr_en is ignored outside IDLE).
//  rsrc==rdest is legal: both operands equal reg[rdest]; the result overwrites it.
//  rd_data reflects writes from the edge after the write (no bypass).
//  Indices >= NREGS are undefined (do not instantiate NREGS<16 with 4-bit indices driven out of range).
//  flags is updated only in CAPTURE; wr_en never modifies flags.
// CONFIGURATION
//  ALU_CMP_NOWB_EN defined:
//   - When the latched opcode == CMP_OPCODE, CAPTURE updates flags and pulses done, but the regfile is NOT written.
//  ALU_CMP_NOWB_EN undefined:
//   - All opcodes, CMP_OPCODE included, write alu_c back to reg[rdest].
// TESTING
//  1 Reset:
//    - Assert reset_n=0 mid-ISSUE.
//    - Required: state IDLE, cmd_ready=1, flags=0, done=0, rd_data=0 for every rd_addr, no writeback.
//  2 Preload + add:
//    - wr reg1=16'h0003, reg2=16'h0004; cmd opcode=ADD, rsrc=1, rdest=2.
//    - Required: alu_src=3, alu_dest=4 at N; reg2=16'h0007 at N+2; done one cycle; flags=ALU flags.
//  3 Overflow/wrap:
//    - reg1=16'hFFFF, reg2=16'h0001, ADD.
//    - Required: reg2=16'h0000, flags carry/zero bits per ALU definition.
//  4 Handshake:
//    - Hold cmd_valid=1 continuously with wr_en pulses.
//    - Required: cmd_ready=0 in ISSUE/CAPTURE and whenever wr_en=1.
//    - Required: exactly one accept per 3 cycles; wr_en during ISSUE leaves regs unchanged.
//  5 Self-operand:
//    - reg5=16'h0010, cmd rsrc=5, rdest=5, ADD.
//    - Required: alu_src=alu_dest=16'h0010; reg5=16'h0020.
//  6 Compare opcode:
//    - reg3=16'h0009, reg4=16'h0009, opcode=CMP_OPCODE.
//    - Required with ALU_CMP_NOWB_EN: reg4 stays 16'h0009, flags updated, done pulses.
//    - Required without ALU_CMP_NOWB_EN: reg4=alu_c.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
// Command front end for the 16-bit combinational ALU. A command names an
// opcode, a source register and a destination register. The sequencer reads
// both operands from its register file, presents them to the ALU for a full
// cycle, then writes the ALU result back to the destination register and
// latches the ALU flags. Each transaction takes three clock cycles.
//
// Optional feature macro: ALU_CMP_NOWB_EN
//   defined   - an opcode equal to CMP_OPCODE updates flags and pulses done,
//               but leaves the register file untouched.
//   undefined - every opcode, CMP_OPCODE included, writes the result back.
module alu_cmd_sequencer #(
   parameter int         NREGS      = 16,
   parameter logic [7:0] CMP_OPCODE = 8'h0B,
   localparam int        AW         = $clog2(NREGS)
) (
   input  logic          clk,
   input  logic          reset_n,
   // command handshake
   input  logic          cmd_valid,
   output logic          cmd_ready,
   input  logic [7:0]    cmd_opcode,
   input  logic [AW-1:0] cmd_rsrc,
   input  logic [AW-1:0] cmd_rdest,
   // host preload and debug read port
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [15:0]   wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [15:0]   rd_data,
   // ALU interface
   output logic [7:0]    alu_opcode,
   output logic [15:0]   alu_src,
   output logic [15:0]   alu_dest,
   input  logic [15:0]   alu_c,
   input  logic [4:0]    alu_flags,
   // status
   output logic [4:0]    flags,
   output logic          done
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ISSUE   = 2'd1,
      ST_CAPTURE = 2'd2
   } state_t;

   state_t          state_reg;
   state_t          state_next;

   // control strobes decoded from the current state
   logic            accept;
   logic            preload;
   logic            capture;
   logic            wb_en;
   logic            wb_allow;

   // datapath registers
   logic [7:0]      opcode_reg;
   logic [15:0]     src_reg;
   logic [15:0]     dest_reg;
   logic [AW-1:0]   rdest_reg;
   logic [4:0]      flags_reg;
   logic            done_reg;

   // register file, one flop vector per entry
   logic [15:0]     regs [NREGS];

   // Compare commands may be excluded from writeback. The opcode register is
   // stable throughout the transaction, so it is safe to decode it in CAPTURE.
`ifdef ALU_CMP_NOWB_EN
   assign wb_allow = (opcode_reg != CMP_OPCODE);
`else
   assign wb_allow = 1'b1;
`endif

   // State register; reset abandons any in-flight command.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state and strobe decode. Host preload beats a pending command, and
   // the preload port is only honoured while idle so it cannot disturb
   // operands already captured for an in-flight command.
   always_comb begin
      state_next = state_reg;
      cmd_ready  = 1'b0;
      accept     = 1'b0;
      preload    = 1'b0;
      capture    = 1'b0;
      wb_en      = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            cmd_ready = ~wr_en;
            if (wr_en) begin
               preload = 1'b1;
            end else if (cmd_valid) begin
               accept     = 1'b1;
               state_next = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            state_next = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            capture    = 1'b1;
            wb_en      = wb_allow;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Operand capture at accept, flag capture and done pulse at writeback.
   // ALU-facing registers keep their values between commands.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         opcode_reg <= '0;
         src_reg    <= '0;
         dest_reg   <= '0;
         rdest_reg  <= '0;
         flags_reg  <= '0;
         done_reg   <= 1'b0;
      end else begin
         done_reg <= capture;
         if (accept) begin
            opcode_reg <= cmd_opcode;
            src_reg    <= regs[cmd_rsrc];
            dest_reg   <= regs[cmd_rdest];
            rdest_reg  <= cmd_rdest;
         end
         if (capture) begin
            flags_reg <= alu_flags;
         end
      end
   end

   // Register file entries. Writeback and preload never coincide because
   // preload is only decoded in IDLE and writeback only in CAPTURE.
   genvar gi;
   generate
      for (gi = 0; gi < NREGS; gi++) begin : g_reg
         logic [15:0] entry_reg;

         // one entry: cleared on reset, loaded by writeback or host preload
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               entry_reg <= '0;
            end else if (wb_en && (rdest_reg == AW'(gi))) begin
               entry_reg <= alu_c;
            end else if (preload && (wr_addr == AW'(gi))) begin
               entry_reg <= wr_data;
            end
         end

         assign regs[gi] = entry_reg;
      end
   endgenerate

   // Debug read is combinational with no write bypass.
   assign rd_data    = regs[rd_addr];

   assign alu_opcode = opcode_reg;
   assign alu_src    = src_reg;
   assign alu_dest   = dest_reg;
   assign flags      = flags_reg;
   assign done       = done_reg;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer. A small combinational ALU model answers the
// DUT's ALU port; a transaction-level reference model (register array, a
// busy countdown and the pending command) predicts every observable output.
module tb_alu_cmd_sequencer;

   localparam logic [7:0] OP_ADD = 8'h01;
   localparam logic [7:0] OP_CMP = 8'h0B;

   logic        clk;
   logic        reset_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_opcode;
   logic [3:0]  cmd_rsrc;
   logic [3:0]  cmd_rdest;
   logic        wr_en;
   logic [3:0]  wr_addr;
   logic [15:0] wr_data;
   logic [3:0]  rd_addr;
   logic [15:0] rd_data;
   logic [7:0]  alu_opcode;
   logic [15:0] alu_src;
   logic [15:0] alu_dest;
   logic [15:0] alu_c;
   logic [4:0]  alu_flags;
   logic [4:0]  flags;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;
   int n_txn    = 0;
   int dut_acc  = 0;

   // reference model state
   logic [15:0] m_regs [16];
   int          m_busy;
   logic [7:0]  m_op;
   logic [15:0] m_src;
   logic [15:0] m_dst;
   logic [3:0]  m_rd;
   logic [4:0]  m_flags;
   logic        m_done;

   alu_cmd_sequencer dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_opcode (cmd_opcode),
      .cmd_rsrc   (cmd_rsrc),
      .cmd_rdest  (cmd_rdest),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .rd_addr    (rd_addr),
      .rd_data    (rd_data),
      .alu_opcode (alu_opcode),
      .alu_src    (alu_src),
      .alu_dest   (alu_dest),
      .alu_c      (alu_c),
      .alu_flags  (alu_flags),
      .flags      (flags),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ALU: C = Dest op Src; flags {parity, overflow, negative, zero, carry/borrow}
   function automatic logic [20:0] alu_fn(input logic [7:0] op, input logic [15:0] s, input logic [15:0] d);
      logic [16:0] w;
      logic [15:0] c;
      logic        ov;
      ov = 1'b0;
      case (op)
         8'h01: begin
            w  = {1'b0, d} + {1'b0, s};
            ov = (d[15] == s[15]) && (w[15] != d[15]);
         end
         8'h02, 8'h0B: begin
            w  = {1'b0, d} - {1'b0, s};
            ov = (d[15] != s[15]) && (w[15] != d[15]);
         end
         8'h03:   w = {1'b0, d & s};
         8'h04:   w = {1'b0, d | s};
         8'h05:   w = {1'b0, d ^ s};
         default: w = {1'b0, d};
      endcase
      c = w[15:0];
      return {^c, ov, c[15], (c == 16'h0000), w[16], c};
   endfunction

   always_comb {alu_flags, alu_c} = alu_fn(alu_opcode, alu_src, alu_dest);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = 16'h0000;
      m_busy  = 0;
      m_op    = 8'h00;
      m_src   = 16'h0000;
      m_dst   = 16'h0000;
      m_rd    = 4'h0;
      m_flags = 5'b0;
      m_done  = 1'b0;
   endtask

   // One clock cycle: drive inputs, check combinational outputs before the
   // edge, advance the model across the edge, check registered outputs after.
   task automatic cycle(input logic v, input logic [7:0] op, input logic [3:0] rs, input logic [3:0] rd,
                        input logic we, input logic [3:0] wa, input logic [15:0] wd, input logic [3:0] ra);
      logic [20:0] r;
      logic        wb;
      cmd_valid  = v;
      cmd_opcode = op;
      cmd_rsrc   = rs;
      cmd_rdest  = rd;
      wr_en      = we;
      wr_addr    = wa;
      wr_data    = wd;
      rd_addr    = ra;
      #1;
      check("cmd_ready", 32'(cmd_ready), 32'((m_busy == 0) && !we));
      check("rd_data", 32'(rd_data), 32'(m_regs[ra]));
      if (cmd_valid && cmd_ready) dut_acc++;
      @(posedge clk);
      m_done = 1'b0;
      if (m_busy == 0) begin
         if (we) begin
            m_regs[wa] = wd;
         end else if (v) begin
            m_op   = op;
            m_src  = m_regs[rs];
            m_dst  = m_regs[rd];
            m_rd   = rd;
            m_busy = 2;
         end
      end else if (m_busy == 2) begin
         m_busy = 1;
      end else begin
         r  = alu_fn(m_op, m_src, m_dst);
         wb = 1'b1;
`ifdef ALU_CMP_NOWB_EN
         if (m_op == OP_CMP) wb = 1'b0;
`endif
         m_flags = r[20:16];
         if (wb) m_regs[m_rd] = r[15:0];
         m_done = 1'b1;
         m_busy = 0;
         n_txn++;
         $display("txn %0d op=%02h src=%04h dst=%04h rd=%0d c=%04h flags=%05b wb=%0d",
                  n_txn, m_op, m_src, m_dst, m_rd, r[15:0], r[20:16], wb);
      end
      #1;
      check("alu_opcode", 32'(alu_opcode), 32'(m_op));
      check("alu_src", 32'(alu_src), 32'(m_src));
      check("alu_dest", 32'(alu_dest), 32'(m_dst));
      check("flags", 32'(flags), 32'(m_flags));
      check("done", 32'(done), 32'(m_done));
   endtask

   task automatic idle();
      cycle(1'b0, 8'h00, 4'h0, 4'h0, 1'b0, 4'h0, 16'h0000, 4'h0);
   endtask

   task automatic preload(input logic [3:0] a, input logic [15:0] d);
      cycle(1'b0, 8'h00, 4'h0, 4'h0, 1'b1, a, d, a);
   endtask

   task automatic peek(input string tag, input logic [3:0] a, input logic [15:0] exp);
      rd_addr = a;
      #1;
      check(tag, 32'(rd_data), 32'(exp));
   endtask

   // Full transaction with fixed expectations for operands and flags.
   task automatic run_cmd(input string tag, input logic [7:0] op, input logic [3:0] rs, input logic [3:0] rd,
                          input logic [15:0] exp_src, input logic [15:0] exp_dst, input logic [4:0] exp_flags);
      cycle(1'b1, op, rs, rd, 1'b0, 4'h0, 16'h0000, rd);
      check({tag, ".src"}, 32'(alu_src), 32'(exp_src));
      check({tag, ".dst"}, 32'(alu_dest), 32'(exp_dst));
      check({tag, ".busy"}, 32'(cmd_ready), 32'(0));
      idle();
      idle();
      check({tag, ".done"}, 32'(done), 32'(1));
      check({tag, ".flags"}, 32'(flags), 32'(exp_flags));
   endtask

   initial begin
      logic [7:0] ops [7];
      ops = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h0B, 8'h00};
      reset_n    = 1'b0;
      cmd_valid  = 1'b0;
      cmd_opcode = 8'h00;
      cmd_rsrc   = 4'h0;
      cmd_rdest  = 4'h0;
      wr_en      = 1'b0;
      wr_addr    = 4'h0;
      wr_data    = 16'h0000;
      rd_addr    = 4'h0;
      model_reset();

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst.ready", 32'(cmd_ready), 32'(1));
      check("rst.done", 32'(done), 32'(0));
      check("rst.flags", 32'(flags), 32'(0));
      check("rst.alu_src", 32'(alu_src), 32'(0));
      @(negedge clk);
      reset_n = 1'b1;

      // preload + add: 3 + 4
      preload(4'd1, 16'h0003);
      preload(4'd2, 16'h0004);
      run_cmd("add", OP_ADD, 4'd1, 4'd2, 16'h0003, 16'h0004, 5'b10000);
      peek("add.reg2", 4'd2, 16'h0007);
      idle();

      // wrap: FFFF + 0001 -> 0000 with carry and zero
      preload(4'd1, 16'hFFFF);
      preload(4'd2, 16'h0001);
      run_cmd("wrap", OP_ADD, 4'd1, 4'd2, 16'hFFFF, 16'h0001, 5'b00011);
      peek("wrap.reg2", 4'd2, 16'h0000);
      idle();

      // handshake: valid held high, one accept per three cycles
      preload(4'd7, 16'h1234);
      dut_acc = 0;
      for (int i = 0; i < 12; i++) cycle(1'b1, OP_ADD, 4'd1, 4'd3, 1'b0, 4'h0, 16'h0000, 4'd3);
      check("hs.accepts", 32'(dut_acc), 32'(4));
      cycle(1'b1, OP_ADD, 4'd1, 4'd3, 1'b0, 4'h0, 16'h0000, 4'd3);
      cycle(1'b1, OP_ADD, 4'd1, 4'd3, 1'b1, 4'd7, 16'hBEEF, 4'd7);
      cycle(1'b1, OP_ADD, 4'd1, 4'd3, 1'b1, 4'd7, 16'hBEEF, 4'd7);
      peek("hs.reg7", 4'd7, 16'h1234);
      for (int i = 0; i < 9; i++) cycle(1'b1, OP_ADD, 4'd1, 4'd3, (i % 2) == 0, 4'd8, 16'(i), 4'd8);

      // self-operand
      idle();
      idle();
      preload(4'd5, 16'h0010);
      run_cmd("self", OP_ADD, 4'd5, 4'd5, 16'h0010, 16'h0010, 5'b10000);
      peek("self.reg5", 4'd5, 16'h0020);
      idle();

      // compare opcode
      preload(4'd3, 16'h0009);
      preload(4'd4, 16'h0009);
      run_cmd("cmp", OP_CMP, 4'd3, 4'd4, 16'h0009, 16'h0009, 5'b00010);
`ifdef ALU_CMP_NOWB_EN
      peek("cmp.reg4", 4'd4, 16'h0009);
`else
      peek("cmp.reg4", 4'd4, 16'h0000);
`endif
      idle();

      // reset in the middle of ISSUE
      preload(4'd1, 16'h0003);
      preload(4'd2, 16'h0004);
      cycle(1'b1, OP_ADD, 4'd1, 4'd2, 1'b0, 4'h0, 16'h0000, 4'd2);
      cmd_valid = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      check("mrst.ready", 32'(cmd_ready), 32'(1));
      check("mrst.done", 32'(done), 32'(0));
      check("mrst.flags", 32'(flags), 32'(0));
      check("mrst.alu_dest", 32'(alu_dest), 32'(0));
      for (int i = 0; i < 16; i++) peek("mrst.reg", 4'(i), 16'h0000);
      @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      for (int i = 0; i < 4; i++) idle();
      peek("mrst.nowb", 4'd2, 16'h0000);

      // randomized traffic against the reference model
      for (int i = 0; i < 300; i++) begin
         cycle(($urandom % 4) != 0, ops[$urandom % 7], 4'($urandom), 4'($urandom),
               ($urandom % 3) == 0, 4'($urandom), 16'($urandom), 4'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   // absolute time bound
   initial begin
      #500000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "time limit reached");
   end

endmodule
